axi4lite_pwm_slave: RTL and testbench
=====================================

Name: axi4lite_pwm_slave

Overview:
- AXI4-Lite slave (responder) holding four 32-bit registers and driving one PWM output.
- Sits behind the interconnect as the S00_AXI end of the PWM core; the bus master programs it through CTRL/PERIOD/DUTY and reads back status.
- Period and duty writes are double-buffered so that a new value takes effect only on a PWM period boundary.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; bits [3:2] select the register, bits [1:0] are ignored.
- C_CNT_WIDTH, 32, width of the PWM counter and of the PERIOD/DUTY fields.

Ports:
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- pwm_out  out  1  registered PWM output.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - All registers, shadows and the counter clear to 0.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID clear to 0; RDATA clears to 0.
  - pwm_out clears to 0.
  - Reset asserted mid-transaction aborts it; no response is issued after reset.
- Register map:
  - 0x0 CTRL: [0] enable, [1] polarity; all other bits read 0.
  - 0x4 PERIOD: full 32 bits, read/write.
  - 0x8 DUTY: full 32 bits, read/write.
  - 0xC COUNT: read-only live counter value; writes complete with OKAY and have no effect.
- Write channel FSM, states W_IDLE → W_RESP:
  - AW and W may arrive in either order or together. Each is held (its READY stays 0) until both VALIDs are seen.
  - In the cycle both VALIDs are high in W_IDLE and BVALID=0, pulse AWREADY and WREADY for exactly 1 cycle.
  - Register update applies per WSTRB byte at that edge. BVALID rises on the next edge.
  - BVALID holds until BREADY; only one write is outstanding at a time.
- Read channel FSM, states R_IDLE → R_DATA:
  - ARREADY pulses for 1 cycle when ARVALID=1 and RVALID=0.
  - RDATA is registered and RVALID is asserted on the next edge (1-cycle latency).
  - RDATA and RVALID hold stable until RREADY.
- The read and write channels are independent and may complete in the same cycle.
  - A read of a register being written in the same cycle returns the old value.
- PWM engine:
  - Active shadows: per_a, duty_a.
  - While enable=0: counter = 0, per_a ← PERIOD and duty_a ← DUTY every cycle, pwm_out = polarity (inactive level).
  - While enable=1:
    - counter increments each cycle.
    - When counter == per_a−1, the counter wraps to 0 and per_a/duty_a reload from the registers.
    - If per_a == 0, the counter holds at 0 and reloads the shadows each cycle.
  - pwm_out (registered, 1-cycle delay from counter) = ((counter < duty_a) && per_a != 0) XOR polarity.
  - duty_a ≥ per_a gives a constant active level; duty_a = 0 gives a constant inactive level.
  - The counter compare is unsigned, C_CNT_WIDTH wide; PERIOD = 0xFFFFFFFF wraps at 0xFFFFFFFE with no overflow.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read back → 0x1, 0x2, 0x3, and COUNT (not 0x4). All BRESP/RRESP = OKAY.
- AW presented 3 cycles before W, then W presented 2 cycles before AW → each write lands once, exactly one BVALID each; BREADY held low for 4 cycles → BVALID stays high and no second write is accepted.
- PERIOD=10, DUTY=3, CTRL=1 → pwm_out repeats 3 high, 7 low; COUNT read cycles through 0..9.
- While running, write DUTY=7 mid-period → the current period keeps 3 high; the next period starts with 7 high. CTRL=3 → the waveform is inverted (7 low, 3 high).
- Boundary cases: DUTY=12 with PERIOD=10 → constant 1; PERIOD=0 → constant 0 and COUNT=0; WSTRB=4'b0001 writing 0xAABBCCDD onto PERIOD=0x11223344 → 0x112233DD.
- Assert ARESET while BVALID and RVALID are pending → both drop to 0, all registers read 0, pwm_out=0.

Source files
------------

// File: rtl/axi4lite_pwm_slave.sv
// AXI4-Lite register slave (CTRL/PERIOD/DUTY/COUNT) driving a double-buffered PWM output.
module axi4lite_pwm_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_CNT_WIDTH        = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              pwm_out
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned CW = C_CNT_WIDTH;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t        r_w_state, w_w_state_nxt;
  r_state_t        r_r_state, w_r_state_nxt;
  logic            r_wr_ready, w_wr_ready_nxt, w_wr_en;
  logic            r_bvalid;
  logic            r_arready, w_arready_nxt, w_rd_en;
  logic            r_rvalid;
  logic [DW-1:0]   r_rdata, w_rd_mux;

  logic [1:0]      r_ctrl;
  logic [DW-1:0]   r_period, r_duty;
  logic [CW-1:0]   r_cnt, r_per_a, r_duty_a;
  logic            r_pwm;
  logic            w_enable, w_pol, w_active, w_wrap;
  logic            w_unused;

  assign S_AXI_AWREADY = r_wr_ready;
  assign S_AXI_WREADY  = r_wr_ready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign pwm_out       = r_pwm;

  assign w_enable = r_ctrl[0];
  assign w_pol    = r_ctrl[1];
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Write FSM state and handshake registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_w_state  <= W_IDLE;
      r_wr_ready <= 1'b0;
      r_bvalid   <= 1'b0;
    end else begin
      r_w_state  <= w_w_state_nxt;
      r_wr_ready <= w_wr_ready_nxt;
      r_bvalid   <= (w_w_state_nxt == W_RESP);
    end
  end

  // Write FSM: wait for both AW and W, pulse ready once, then hold BVALID until BREADY
  always_comb begin
    w_w_state_nxt  = r_w_state;
    w_wr_ready_nxt = 1'b0;
    w_wr_en        = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if (r_wr_ready) begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            w_wr_en       = 1'b1;
            w_w_state_nxt = W_RESP;
          end
        end else if (S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid) begin
          w_wr_ready_nxt = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_w_state_nxt = W_IDLE;
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  // Read FSM state, handshake and registered read data
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_r_state <= w_r_state_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= (w_r_state_nxt == R_DATA);
      if (w_rd_en) r_rdata <= w_rd_mux;
    end
  end

  // Read FSM: single ARREADY pulse, data presented the next cycle until RREADY
  always_comb begin
    w_r_state_nxt = r_r_state;
    w_arready_nxt = 1'b0;
    w_rd_en       = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        if (r_arready) begin
          if (S_AXI_ARVALID) begin
            w_rd_en       = 1'b1;
            w_r_state_nxt = R_DATA;
          end
        end else if (S_AXI_ARVALID && !r_rvalid) begin
          w_arready_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) w_r_state_nxt = R_IDLE;
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // Read data select; sampled pre-edge so a same-cycle write returns the old value
  always_comb begin
    w_rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd0:    w_rd_mux = DW'(r_ctrl);
      2'd1:    w_rd_mux = r_period;
      2'd2:    w_rd_mux = r_duty;
      default: w_rd_mux = DW'(r_cnt);
    endcase
  end

  // Register file with per-byte strobes; COUNT is read-only
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ctrl   <= '0;
      r_period <= '0;
      r_duty   <= '0;
    end else if (w_wr_en) begin
      case (S_AXI_AWADDR[3:2])
        2'd0: if (S_AXI_WSTRB[0]) r_ctrl <= S_AXI_WDATA[1:0];
        2'd1: for (int unsigned b = 0; b < SW; b++)
                if (S_AXI_WSTRB[b]) r_period[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        2'd2: for (int unsigned b = 0; b < SW; b++)
                if (S_AXI_WSTRB[b]) r_duty[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        default: ;
      endcase
    end
  end

  assign w_active = (r_cnt < r_duty_a) && (r_per_a != '0);
  assign w_wrap   = (r_per_a == '0) || (r_cnt == r_per_a - CW'(1));

  // PWM engine: shadows reload only at period wrap (or continuously while idle)
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt    <= '0;
      r_per_a  <= '0;
      r_duty_a <= '0;
      r_pwm    <= 1'b0;
    end else if (!w_enable) begin
      r_cnt    <= '0;
      r_per_a  <= CW'(r_period);
      r_duty_a <= CW'(r_duty);
      r_pwm    <= w_pol;
    end else begin
      r_pwm <= w_active ^ w_pol;
      if (w_wrap) begin
        r_cnt    <= '0;
        r_per_a  <= CW'(r_period);
        r_duty_a <= CW'(r_duty);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_pwm_slave.sv
// Randomized self-checking bench for axi4lite_pwm_slave with a behavioural register/PWM model.
module tb_axi4lite_pwm_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        pwm_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  logic [31:0] mreg [3];

  axi4lite_pwm_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .pwm_out(pwm_out)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Master write; AW/W offsets in cycles, bhold = cycles BREADY stays low with a decoy write pending
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int bhold);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int hold_err = 0, guard = 0, errs = 0;
    while (!(aw_done && w_done) && guard < 60) begin
      if (!aw_done && guard >= aw_dly) begin S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1; end
      if (!w_done && guard >= w_dly) begin
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      end
      @(negedge ACLK);
      if ((S_AXI_AWREADY || S_AXI_WREADY) && !(S_AXI_AWVALID && S_AXI_WVALID)) hold_err++;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; end
      guard++;
    end
    check_eq("wr_accept", 64'(aw_done && w_done), 1);
    check_eq("wr_ready_held", 64'(hold_err), 0);
    if (addr[3:2] == 2'd0)      mreg[0] = merge(mreg[0], data, strb) & 32'h3;
    else if (addr[3:2] != 2'd3) mreg[addr[3:2]] = merge(mreg[addr[3:2]], data, strb);
    guard = 0;
    @(negedge ACLK);
    while (!S_AXI_BVALID && guard < 20) begin @(negedge ACLK); guard++; end
    check_eq("wr_b_latency", 64'(guard), 0);
    check_eq("wr_ready_pulse", 64'(S_AXI_AWREADY || S_AXI_WREADY), 0);
    if (bhold > 0) begin
      @(posedge ACLK); #1;
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = ~data; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      repeat (bhold) begin
        @(negedge ACLK);
        if (!S_AXI_BVALID) errs++;
        if (S_AXI_AWREADY || S_AXI_WREADY) errs++;
      end
      check_eq("wr_bhold", 64'(errs), 0);
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check_eq("wr_bresp", {61'd0, S_AXI_BVALID, S_AXI_BRESP}, 64'h4);
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check_eq("wr_bvalid_once", 64'(S_AXI_BVALID), 0);
    @(posedge ACLK); #1;
  endtask

  // Master read; rhold = cycles RREADY stays low; stamp = cycle index of the address handshake
  task automatic axi_read(input logic [3:0] addr, input int rhold,
                          output logic [31:0] data, output longint stamp);
    bit done = 0;
    int guard = 0, errs = 0;
    logic [31:0] d0;
    stamp = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!done && guard < 40) begin
      @(negedge ACLK);
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin done = 1; stamp = cyc; end
      @(posedge ACLK); #1;
      if (done) S_AXI_ARVALID = 1'b0;
      guard++;
    end
    S_AXI_ARVALID = 1'b0;
    check_eq("rd_accept", 64'(done), 1);
    guard = 0;
    @(negedge ACLK);
    while (!S_AXI_RVALID && guard < 20) begin @(negedge ACLK); guard++; end
    check_eq("rd_latency", 64'(guard), 0);
    d0 = S_AXI_RDATA;
    repeat (rhold) begin
      @(posedge ACLK); #1;
      @(negedge ACLK);
      if (!S_AXI_RVALID || S_AXI_RDATA !== d0) errs++;
    end
    check_eq("rd_hold", 64'(errs), 0);
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    check_eq("rd_rresp", {61'd0, S_AXI_RVALID, S_AXI_RRESP}, 64'h4);
    data = S_AXI_RDATA;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    check_eq("rd_rvalid_once", 64'(S_AXI_RVALID), 0);
    @(posedge ACLK); #1;
  endtask

  // Program PWM from disabled, then compare one period of the waveform to the ideal shape
  task automatic check_pwm(input string tag, input int p, input int d, input bit pol);
    bit s [64];
    int n, a, k, errs;
    bit act, lvl;
    logic [63:0] obs, exp;
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'(p), 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'(d), 4'hF, 0, 0, 0);
    axi_write(4'h0, {30'd0, pol, 1'b1}, 4'hF, 0, 0, 0);
    n = (p >= 2 && p <= 16) ? 3 * p + 4 : 24;
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      s[i] = pwm_out;
      @(posedge ACLK); #1;
    end
    act = ~pol;
    a = (d >= p) ? p : d;
    if (a == 0 || a == p) begin
      lvl = (a == 0) ? pol : ~pol;
      errs = 0;
      for (int i = 0; i < n; i++) if (s[i] != lvl) errs++;
      check_eq({tag, "_const"}, 64'(errs), 0);
    end else begin
      k = -1;
      for (int i = 1; i < n; i++) if (k < 0 && s[i] == act && s[i-1] != act) k = i;
      if (k < 0 || k + p > n) check_eq({tag, "_edge"}, 0, 1);
      else begin
        obs = '0; exp = '0;
        for (int j = 0; j < p; j++) begin
          obs[j] = s[k+j];
          exp[j] = (j < a) ? act : ~act;
        end
        check_eq({tag, "_shape"}, obs, exp);
      end
    end
  endtask

  initial begin
    logic [31:0] rd, c0;
    longint t0, t;
    int idx, p, d;
    bit s [64];
    int k;
    logic [19:0] obs20, exp20;
    bit aw_done, ar_done, aw_hs, ar_hs;
    int guard;

    mreg = '{32'h0, 32'h0, 32'h0};
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    check_eq("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                               S_AXI_RVALID, pwm_out, S_AXI_RDATA}, 64'h0);
    @(posedge ACLK); #1;

    // Plain register map
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0);
    axi_read(4'h0, 0, rd, t); check_eq("map_ctrl", rd, mreg[0]);
    axi_read(4'h4, 0, rd, t); check_eq("map_period", rd, mreg[1]);
    axi_read(4'h8, 0, rd, t); check_eq("map_duty", rd, mreg[2]);
    axi_read(4'hC, 0, rd, t); check_eq("map_count_ro", 64'(rd < 32'd2), 1);
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, 0);

    // Channel ordering and back-pressure
    axi_write(4'h4, 32'h1234_5678, 4'hF, 0, 3, 4);
    axi_write(4'h8, 32'h0000_9ABC, 4'hF, 2, 0, 0);
    axi_read(4'h4, 1, rd, t); check_eq("order_period", rd, mreg[1]);
    axi_read(4'h8, 0, rd, t); check_eq("order_duty", rd, mreg[2]);

    // Randomized register traffic
    for (int it = 0; it < 8; it++) begin
      idx = int'($urandom_range(0, 2));
      axi_write({2'(idx), 2'($urandom)}, $urandom, 4'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      axi_read({2'(idx), 2'($urandom)}, int'($urandom_range(0, 2)), rd, t);
      check_eq("rand_reg", rd, mreg[idx]);
    end

    // Basic PWM and COUNT phase
    check_pwm("pwm_10_3", 10, 3, 1'b0);
    axi_read(4'hC, 0, c0, t0);
    check_eq("count_range", 64'(c0 < 32'd10), 1);
    for (int i = 0; i < 5; i++) begin
      axi_read(4'hC, int'($urandom_range(0, 2)), rd, t);
      check_eq("count_phase", rd, 32'((longint'(c0) + (t - t0)) % 10));
    end

    // DUTY change mid-period only takes effect on the next period
    fork
      begin
        for (int i = 0; i < 40; i++) begin @(negedge ACLK); s[i] = pwm_out; end
      end
      begin
        bit prev, seen;
        int g;
        seen = 0; g = 0;
        @(negedge ACLK); prev = pwm_out;
        while (!seen && g < 30) begin
          @(negedge ACLK);
          if (pwm_out && !prev) seen = 1;
          prev = pwm_out; g++;
        end
        @(posedge ACLK); #1;
        axi_write(4'h8, 32'd7, 4'hF, 0, 0, 0);
      end
    join
    @(posedge ACLK); #1;
    k = -1;
    for (int i = 1; i < 40; i++) if (k < 0 && s[i] && !s[i-1]) k = i;
    if (k < 0 || k + 20 > 40) check_eq("duty_midperiod_edge", 0, 1);
    else begin
      for (int j = 0; j < 20; j++) begin
        obs20[j] = s[k+j];
        exp20[j] = (j < 3) || (j >= 10 && j < 17);
      end
      check_eq("duty_midperiod", 64'(obs20), 64'(exp20));
    end
    check_pwm("pwm_inverted", 10, 7, 1'b1);

    // Randomized PWM shapes
    for (int it = 0; it < 4; it++) begin
      p = int'($urandom_range(2, 12));
      d = int'($urandom_range(0, p + 2));
      check_pwm("pwm_rand", p, d, 1'($urandom));
    end

    // Boundaries
    check_pwm("pwm_duty_ge_period", 10, 12, 1'b0);
    check_pwm("pwm_period0", 0, 5, 1'b0);
    axi_read(4'hC, 0, rd, t); check_eq("count_period0", rd, 32'h0);
    axi_write(4'h4, 32'h1122_3344, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0001, 0, 0, 0);
    axi_read(4'h4, 0, rd, t);
    check_eq("wstrb_byte0", rd, 32'h1122_33DD);
    check_eq("wstrb_model", rd, mreg[1]);

    // Reset while a write response and read data are both pending
    check_pwm("pwm_pre_reset", 10, 12, 1'b0);
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    aw_done = 0; ar_done = 0; guard = 0;
    while (!(aw_done && ar_done) && guard < 20) begin
      @(negedge ACLK);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WREADY;
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; aw_done = 1; end
      if (ar_hs) begin S_AXI_ARVALID = 1'b0; ar_done = 1; end
      guard++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    check_eq("rst_pending", {62'd0, S_AXI_BVALID, S_AXI_RVALID}, 64'h3);
    check_eq("rst_pre_pwm", 64'(pwm_out), 1);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    mreg = '{32'h0, 32'h0, 32'h0};
    @(negedge ACLK);
    check_eq("rst_abort", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                           S_AXI_RVALID, pwm_out, S_AXI_RDATA}, 64'h0);
    @(posedge ACLK); #1;
    axi_read(4'h0, 0, rd, t); check_eq("rst_ctrl", rd, 32'h0);
    axi_read(4'h4, 0, rd, t); check_eq("rst_period", rd, 32'h0);
    axi_read(4'h8, 0, rd, t); check_eq("rst_duty", rd, 32'h0);
    axi_read(4'hC, 0, rd, t); check_eq("rst_count", rd, 32'h0);
    @(negedge ACLK);
    check_eq("rst_pwm_after", 64'(pwm_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
